// File: rtl/imem_loader.sv
// imem_loader: receives a program image over a byte stream (length, data, checksum)
// and writes it byte by byte into the instruction memory write port. The core is held
// in reset while a load is running and is released only after a load whose length and
// XOR checksum were both good.
//
// Stream layout: len[7:0], len[15:8], 4*len data bytes (little-endian words), chk.
module imem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  // Byte index spans 4 * 65535 data bytes at most, so 18 bits always suffice.
  localparam int          IDX_W   = 18;
  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  // Load bookkeeping
  logic [7:0]       len_lo_q;
  logic [15:0]      len_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       xor_q;
  logic [15:0]      word_cnt_q;

  // Write-port stage, one cycle behind byte acceptance
  logic                  wr_vld_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic [7:0]            wr_data_p1;

  // Decoded control
  logic             load_start;
  logic             xfer;
  logic [15:0]      len_full;
  logic [IDX_W-1:0] last_idx;

  // A length is usable only when it names at least one word and fits the memory.
  function automatic logic len_ok(input logic [15:0] len);
    return (len != 16'd0) && ({16'd0, len} <= MAX_LEN);
  endfunction

  assign xfer     = rx_valid && rx_ready;
  assign len_full = {rx_data, len_lo_q};
  assign last_idx = {len_q, 2'b00} - IDX_W'(1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    state_d    = state_q;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    load_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_d    = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_d = len_ok(len_full) ? S_DATA : S_ERR;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid && (idx_q == last_idx)) state_d = S_CHK;
      end
      S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) begin
          load_start = 1'b1;
          state_d    = S_LEN_LO;
        end
      end
      S_ERR: begin
        error = 1'b1;
        if (start) begin
          load_start = 1'b1;
          state_d    = S_LEN_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Length capture, byte index, checksum and word counting on accepted bytes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      if (load_start) begin
        len_q      <= '0;
        idx_q      <= '0;
        xor_q      <= '0;
        word_cnt_q <= '0;
      end
      if (xfer && (state_q == S_LEN_LO)) len_lo_q <= rx_data;
      if (xfer && (state_q == S_LEN_HI)) len_q <= len_full;
      if (xfer && (state_q == S_DATA)) begin
        idx_q <= idx_q + IDX_W'(1);
        xor_q <= xor_q ^ rx_data;
        // Counted together with the write of a word's final byte.
        if (idx_q[1:0] == 2'b11) word_cnt_q <= word_cnt_q + 16'd1;
      end
    end
  end

  // ---- p1: memory write stage (address/data hold between pulses) ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= BASE_ADDR;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= xfer && (state_q == S_DATA);
      if (xfer && (state_q == S_DATA)) begin
        wr_addr_p1 <= BASE_ADDR + ADDR_WIDTH'(idx_q);
        wr_data_p1 <= rx_data;
      end
    end
  end

  assign mem_we     = wr_vld_p1;
  assign mem_addr   = wr_addr_p1;
  assign mem_wdata  = wr_data_p1;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of complete loads (good, bad checksum,
// bad lengths, gapped streams, maximum length, ignored start), plus hand-written
// sequences for reset behaviour and a mid-load asynchronous reset.
module tb_imem_loader;

  localparam int MAXW = 256;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;

  imem_loader #(
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h0),
    .MAX_WORDS  (MAXW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every write pulse the DUT issues, including any stray ones.
  always @(posedge clk) begin
    if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] len;
    int          chk;        // -1: bench computes the XOR of the data bytes
    bit          gaps;
    bit          poke_start;
    bit          exp_done;
    bit          exp_err;
    int          exp_wc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] dbyte(input int i);
    case (i)
      0: return 8'h33;
      1: return 8'h03;
      2: return 8'h94;
      3: return 8'h00;
      4: return 8'h33;
      5: return 8'h00;
      6: return 8'h01;
      7: return 8'h80;
      default: return 8'((i * 37 + 5) & 255);
    endcase
  endfunction

  // Offer one byte, wait (bounded) for acceptance, then check the write it causes.
  task automatic send(input logic [7:0] b, input bit is_data, input int idx,
                      input bit gap, input bit poke);
    int n;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (poke) start = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      n_checks++;
      $display("FAIL rx_ready_wait: got 0 expected 1 (byte %0h)", b);
      rx_valid = 1'b0;
      start    = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    check("mem_we_after_byte", mem_we, is_data);
    if (is_data) begin
      check("mem_addr", mem_addr, 32'(idx));
      check("mem_wdata", mem_wdata, b);
      check("word_count_run", word_count, 32'((idx + 1) / 4));
    end
  endtask

  task automatic run_load(input vec_t v);
    int       we0;
    int       ndata;
    bit       ok;
    logic [7:0] c;
    ok    = (v.len != 16'd0) && (int'(v.len) <= MAXW);
    ndata = ok ? 4 * int'(v.len) : 0;
    c = 8'h00;
    for (int i = 0; i < ndata; i++) c = c ^ dbyte(i);
    if (v.chk >= 0) c = 8'(v.chk);
    we0 = we_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_rx_ready", rx_ready, 1'b1);
    check("start_cpu_reset", cpu_reset, 1'b1);
    check("start_done", done, 1'b0);
    check("start_error", error, 1'b0);
    check("start_word_count", word_count, 0);
    send(v.len[7:0], 1'b0, 0, v.gaps, 1'b0);
    send(v.len[15:8], 1'b0, 0, v.gaps, 1'b0);
    if (ok) begin
      for (int i = 0; i < ndata; i++)
        send(dbyte(i), 1'b1, i, v.gaps, v.poke_start && (i == 3));
      send(c, 1'b0, 0, v.gaps, 1'b0);
    end
    check("end_done", done, v.exp_done);
    check("end_error", error, v.exp_err);
    check("end_cpu_reset", cpu_reset, !v.exp_done);
    check("end_busy", busy, 1'b0);
    check("end_rx_ready", rx_ready, 1'b0);
    check("end_word_count", word_count, 32'(v.exp_wc));
    check("write_pulses", 32'(we_cnt - we0), 32'(ndata));
  endtask

  task automatic check_reset_vals();
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_word_count", word_count, 0);
  endtask

  initial begin
    //         len       chk     gaps poke done err wc
    vecs[0] = '{16'd2,   'h16,   0,   0,   1,   0,  2};
    vecs[1] = '{16'd2,   'h17,   0,   0,   0,   1,  2};
    vecs[2] = '{16'd0,   0,      0,   0,   0,   1,  0};
    vecs[3] = '{16'd257, 0,      0,   0,   0,   1,  0};
    vecs[4] = '{16'd2,   'h16,   1,   0,   1,   0,  2};
    vecs[5] = '{16'd1,   'hA4,   1,   0,   1,   0,  1};
    vecs[6] = '{16'd256, -1,     0,   0,   1,   0,  256};
    vecs[7] = '{16'd2,   'h16,   0,   1,   1,   0,  2};

    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;

    // IDLE must refuse bytes and ignore them.
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (2) @(negedge clk);
    check("idle_rx_ready", rx_ready, 1'b0);
    check("idle_busy", busy, 1'b0);
    rx_valid = 1'b0;

    for (int k = 0; k < 8; k++) run_load(vecs[k]);

    // DONE holds and refuses bytes until the next start.
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("done_hold", done, 1'b1);
    check("done_rx_ready", rx_ready, 1'b0);
    rx_valid = 1'b0;

    // Asynchronous reset in the middle of the data phase.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8'h02, 1'b0, 0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(dbyte(i), 1'b1, i, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_ready", rx_ready, 1'b0);
    run_load(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
